// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and parity helper.
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  function automatic logic parity_calc(input logic [DATA_BITS-1:0] data, input logic even);
    return even ? ^data : ~^data;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the serial line, resets to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], i_d};
  assign o_q = r_sync[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: one-sample-per-clock UART receiver with valid/ack holding register.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchroniser (+2 cycles latency).
module uart_rx
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 even_parity,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);
  logic                 w_rx;
  rx_state_t            r_state;
  logic [2:0]           r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_en;
  logic                 r_even;
  logic                 r_par_bit;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_overrun;
  logic                 r_busy;
`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .i_d(rx), .o_q(w_rx));
`else
  assign w_rx = rx;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_even    <= 1'b0;
      r_par_bit <= 1'b0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (rx_ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
      case (r_state)
        IDLE: if (!w_rx) begin
          r_state  <= DATA;
          r_busy   <= 1'b1;
          r_cnt    <= '0;
          r_par_en <= parity_en;
          r_even   <= even_parity;
        end
        DATA: begin
          r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= r_par_en ? PARITY : STOP;
        end
        PARITY: begin
          r_par_bit <= w_rx;
          r_state   <= STOP;
        end
        STOP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_data  <= r_shift;
          r_perr  <= r_par_en && (r_par_bit != parity_calc(r_shift, r_even));
          r_ferr  <= ~w_rx;
          r_valid <= 1'b1;
          // an ack on the completing edge hands the old byte over, so no overrun
          if (r_valid && !rx_ack) r_overrun <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign rx_busy    = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; frames are driven bit-per-clock on negedges.
`timescale 1ns/1ps
module tb_uart_rx;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       even_parity = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, rx_busy;
  exp_t       exp_q[$];
  exp_t       e;
  logic       v_before;
  int         n_chk = 0;
  int         n_pass = 0;

  uart_rx dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .parity_en(parity_en), .even_parity(even_parity),
    .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Drives one frame and pushes its expected result; returns on the negedge after the STOP edge.
  // parity_en/even_parity are flipped mid-frame to show they are latched at the start bit.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic ev,
                            input logic pbit, input logic stop, input logic ack);
    exp_t x;
    x.d  = d;
    x.pe = pe && (pbit != (ev ? ^d : ~^d));
    x.fe = ~stop;
    exp_q.push_back(x);
    @(negedge clk); rx = 1'b0; parity_en = pe; even_parity = ev;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx = d[i];
      if (i == 3) begin parity_en = ~pe; even_parity = ~ev; end
    end
    if (pe) begin @(negedge clk); rx = pbit; end
    @(negedge clk); rx = stop;
    repeat (SYNC) begin @(negedge clk); rx = 1'b1; end
    v_before = rx_valid;
    rx_ack = ack;
    @(negedge clk); rx = 1'b1; rx_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy} !== 13'd0)
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b, want all 0",
               rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({rx_valid, rx_busy} !== 2'b00) $display("FAIL idle_after_reset: v=%b busy=%b, want 0 0", rx_valid, rx_busy);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [11:0] tbl [3];
    tbl[0] = {8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1] = {8'hA5, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2] = {8'hA5, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      send_frame(tbl[k][11:4], tbl[k][3], tbl[k][2], tbl[k][1], tbl[k][0], 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (v_before !== 1'b0) $display("FAIL parity%0d_early_valid: got %b want 0", k, v_before);
      else n_pass++;
      n_chk++;
      if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e.d, e.pe, e.fe, 1'b0})
        $display("FAIL parity%0d_result: got v=%b d=%h pe=%b fe=%b ov=%b want v=1 d=%h pe=%b fe=%b ov=0",
                 k, rx_valid, rx_data, parity_err, frame_err, overrun, e.d, e.pe, e.fe);
      else n_pass++;
      ack_pulse();
      n_chk++;
      if (rx_valid !== 1'b0) $display("FAIL parity%0d_ack: rx_valid=%b want 0", k, rx_valid);
      else n_pass++;
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_chk++;
    if (v_before !== 1'b0) $display("FAIL frame_early_valid: got %b want 0", v_before);
    else n_pass++;
    n_chk++;
    if ({rx_valid, rx_data, parity_err, frame_err, rx_busy} !== {1'b1, e.d, e.pe, e.fe, 1'b0})
      $display("FAIL frame_result: got v=%b d=%h pe=%b fe=%b busy=%b want v=1 d=%h pe=%b fe=%b busy=0",
               rx_valid, rx_data, parity_err, frame_err, rx_busy, e.d, e.pe, e.fe);
    else n_pass++;
    ack_pulse();
    n_chk++;
    if (rx_valid !== 1'b0) $display("FAIL frame_ack: rx_valid=%b want 0", rx_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_chk++;
    if ({rx_valid, rx_data, overrun} !== {1'b1, e.d, 1'b0})
      $display("FAIL b2b_first: got v=%b d=%h ov=%b want v=1 d=%h ov=0", rx_valid, rx_data, overrun, e.d);
    else n_pass++;
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_chk++;
    if ({rx_valid, rx_data, frame_err, overrun} !== {1'b1, e.d, e.fe, 1'b1})
      $display("FAIL b2b_overrun: got v=%b d=%h fe=%b ov=%b want v=1 d=%h fe=%b ov=1",
               rx_valid, rx_data, frame_err, overrun, e.d, e.fe);
    else n_pass++;
    ack_pulse();
    n_chk++;
    if ({rx_valid, overrun} !== 2'b00) $display("FAIL b2b_ack: got v=%b ov=%b want 0 0", rx_valid, overrun);
    else n_pass++;
    ack_pulse();
    n_chk++;
    if ({rx_valid, overrun} !== 2'b00) $display("FAIL b2b_idle_ack: got v=%b ov=%b want 0 0", rx_valid, overrun);
    else n_pass++;
  endtask

  task automatic test_ack_on_stop();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_chk++;
    if ({rx_valid, rx_data, parity_err, overrun} !== {1'b1, e.d, e.pe, 1'b0})
      $display("FAIL ack_on_stop: got v=%b d=%h pe=%b ov=%b want v=1 d=%h pe=%b ov=0",
               rx_valid, rx_data, parity_err, overrun, e.d, e.pe);
    else n_pass++;
    ack_pulse();
    n_chk++;
    if (rx_valid !== 1'b0) $display("FAIL ack_on_stop_clear: rx_valid=%b want 0", rx_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    @(negedge clk); rx = 1'b0; parity_en = 1'b1; even_parity = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); rx = 1'b1; end
    n_chk++;
    if (rx_busy !== 1'b1) $display("FAIL midframe_busy: rx_busy=%b want 1", rx_busy);
    else n_pass++;
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    n_chk++;
    if ({rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy} !== 13'd0)
      $display("FAIL midframe_reset: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b want all 0",
               rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_chk++;
    if ({rx_valid, rx_busy} !== 2'b00) $display("FAIL midframe_abandoned: v=%b busy=%b want 0 0", rx_valid, rx_busy);
    else n_pass++;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_chk++;
    if ({v_before, rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b0, 1'b1, e.d, e.pe, e.fe, 1'b0})
      $display("FAIL midframe_recover: got pre=%b v=%b d=%h pe=%b fe=%b ov=%b want pre=0 v=1 d=%h pe=%b fe=%b ov=0",
               v_before, rx_valid, rx_data, parity_err, frame_err, overrun, e.d, e.pe, e.fe);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_parity();
    test_frame_err();
    test_back_to_back();
    test_ack_on_stop();
    test_reset_midframe();
    n_chk++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
